// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle between the MEM-stage access unit and the data memory.
// The unit drives the request side through the master modport; the memory
// (or a testbench model of it) uses the slave modport.
interface mem_access_unit_if;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [31:0] DMemWData;
  logic        DMemAck;
  logic [31:0] DMemRData;

  modport master (
    output DMemReq,
    output DMemWe,
    output DMemAddr,
    output DMemWData,
    input  DMemAck,
    input  DMemRData
  );

  modport slave (
    input  DMemReq,
    input  DMemWe,
    input  DMemAddr,
    input  DMemWData,
    output DMemAck,
    output DMemRData
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Turns MemReadM/MemWriteM into one req/ack transaction on the data-memory port,
// stalls the pipeline until it completes, then holds RDM for MEM/WB to sample.
// Misaligned accesses and accesses that time out are reported on BusErrM.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          ALIGN_CHECK    = 1'b1
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [31:0]            ALUOutM,
  input  logic [31:0]            WriteDataM,
  mem_access_unit_if.master      dmem,
  output logic [31:0]            RDM,
  output logic                   StallM,
  output logic                   BusErrM
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} stateT;

  // Last counter value before the request is abandoned.
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  stateT       stateQ, stateD;
  logic [7:0]  cntQ, cntD;
  logic        reqQ, reqD;
  logic        weQ, weD;
  logic [31:0] addrQ, addrD;
  logic [31:0] wdataQ, wdataD;
  logic [31:0] rdmQ, rdmD;
  logic        errQ, errD;

  logic access;
  logic misaligned;

  assign access     = MemReadM | MemWriteM;
  assign misaligned = ALIGN_CHECK && (ALUOutM[1:0] != 2'b00);

  assign dmem.DMemReq   = reqQ;
  assign dmem.DMemWe    = weQ;
  assign dmem.DMemAddr  = addrQ;
  assign dmem.DMemWData = wdataQ;
  assign RDM            = rdmQ;
  assign BusErrM        = errQ;

  // Next-state, registered-output updates and the combinational stall.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    reqD   = reqQ;
    weD    = weQ;
    addrD  = addrQ;
    wdataD = wdataQ;
    rdmD   = rdmQ;
    errD   = errQ;
    StallM = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (access) begin
          StallM = 1'b1;
          if (misaligned) begin
            // No bus traffic; report the error straight away.
            errD   = 1'b1;
            if (!MemWriteM) begin
              rdmD = 32'h0;
            end
            stateD = StDone;
          end else begin
            addrD  = ALUOutM;
            wdataD = WriteDataM;
            weD    = MemWriteM;  // store wins when both are asserted
            reqD   = 1'b1;
            cntD   = 8'h00;
            stateD = StReq;
          end
        end
      end

      StReq: begin
        StallM = 1'b1;
        if (dmem.DMemAck) begin
          reqD = 1'b0;
          errD = 1'b0;
          if (!weQ) begin
            rdmD = dmem.DMemRData;
          end
          stateD = StDone;
        end else if (cntQ == CntLast) begin
          reqD = 1'b0;
          errD = 1'b1;
          if (!weQ) begin
            rdmD = 32'h0;
          end
          stateD = StDone;
        end else begin
          // Only incremented below CntLast, so it can never wrap.
          cntD = cntQ + 8'd1;
        end
      end

      StDone: begin
        // Pipeline advances this cycle; the next instruction is seen in StIdle.
        errD   = 1'b0;
        stateD = StIdle;
      end

      default: begin
        stateD = StIdle;
      end
    endcase

    if (rst) begin
      StallM = 1'b0;
    end
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      stateQ <= StIdle;
      cntQ   <= 8'h00;
      reqQ   <= 1'b0;
      weQ    <= 1'b0;
      addrQ  <= 32'h0;
      wdataQ <= 32'h0;
      rdmQ   <= 32'h0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      reqQ   <= reqD;
      weQ    <= weD;
      addrQ  <= addrD;
      wdataQ <= wdataD;
      rdmQ   <= rdmD;
      errQ   <= errD;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios followed by randomized
// transactions, each checked against a transaction-level expectation.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        CLK = 1'b0;
  logic        rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] RDM;
  logic        StallM;
  logic        BusErrM;

  mem_access_unit_if dmem ();

  mem_access_unit #(
    .TIMEOUT_CYCLES(TO),
    .ALIGN_CHECK   (1'b1)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .ALUOutM   (ALUOutM),
    .WriteDataM(WriteDataM),
    .dmem      (dmem),
    .RDM       (RDM),
    .StallM    (StallM),
    .BusErrM   (BusErrM)
  );

  always #5 CLK = ~CLK;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [31:0] rdmModel = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic stepClk();
    @(posedge CLK);
    #1;
  endtask

  // Runs one access from IDLE through DONE and back to IDLE. waits = number of
  // REQ cycles without ack before the ack; waits >= TO means the memory never acks.
  task automatic doAccess(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int waits);
    int stallCnt = 0;
    int reqCnt = 0;
    bit done = 0;
    bit isRead;
    bit mis;
    int expStall;
    int expReq;
    logic expErr;
    logic [31:0] expRdm;

    isRead = rd && !wr;
    mis    = (addr[1:0] != 2'b00);
    if (mis) begin
      expStall = 1;
      expReq   = 0;
      expErr   = 1'b1;
      expRdm   = isRead ? 32'h0 : rdmModel;
    end else if (waits < int'(TO)) begin
      expStall = 2 + waits;
      expReq   = waits + 1;
      expErr   = 1'b0;
      expRdm   = isRead ? rdata : rdmModel;
    end else begin
      expStall = 1 + int'(TO);
      expReq   = int'(TO);
      expErr   = 1'b1;
      expRdm   = isRead ? 32'h0 : rdmModel;
    end

    MemReadM      = rd;
    MemWriteM     = wr;
    ALUOutM       = addr;
    WriteDataM    = wdata;
    dmem.DMemAck  = 1'b0;

    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!StallM) begin
        done = 1;
      end else begin
        stallCnt++;
        if (dmem.DMemReq) begin
          reqCnt++;
          chk("addr_stable", dmem.DMemAddr, addr);
          chk("wdata_stable", dmem.DMemWData, wdata);
          chk("we", 32'(dmem.DMemWe), 32'(wr));
          dmem.DMemAck   = ((reqCnt - 1) == waits);
          dmem.DMemRData = dmem.DMemAck ? rdata : $urandom;
        end else begin
          dmem.DMemAck = 1'b0;
        end
        stepClk();
      end
    end
    if (!done) chk("done_reached", 32'h0, 32'h1);

    chk("stall_cycles", 32'(stallCnt), 32'(expStall));
    chk("req_cycles", 32'(reqCnt), 32'(expReq));
    chk("buserr_done", 32'(BusErrM), 32'(expErr));
    chk("rdm_done", RDM, expRdm);
    chk("no_req_in_done", 32'(dmem.DMemReq), 32'h0);
    rdmModel = expRdm;

    // Stray ack in DONE must be ignored.
    dmem.DMemAck   = 1'($urandom_range(0, 1));
    dmem.DMemRData = $urandom;
    stepClk();
    dmem.DMemAck = 1'b0;
    MemReadM     = 1'b0;
    MemWriteM    = 1'b0;
    #1;
    chk("idle_buserr", 32'(BusErrM), 32'h0);
    chk("idle_stall", 32'(StallM), 32'h0);
    chk("idle_rdm", RDM, rdmModel);
    chk("idle_req", 32'(dmem.DMemReq), 32'h0);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_req"}, 32'(dmem.DMemReq), 32'h0);
    chk({tag, "_we"}, 32'(dmem.DMemWe), 32'h0);
    chk({tag, "_addr"}, dmem.DMemAddr, 32'h0);
    chk({tag, "_wdata"}, dmem.DMemWData, 32'h0);
    chk({tag, "_rdm"}, RDM, 32'h0);
    chk({tag, "_buserr"}, 32'(BusErrM), 32'h0);
    chk({tag, "_stall"}, 32'(StallM), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic rd;
    logic wr;
    int idles;

    // Reset, with a pending load to show StallM is forced low.
    rst            = 1'b1;
    MemReadM       = 1'b1;
    MemWriteM      = 1'b0;
    ALUOutM        = 32'h4;
    WriteDataM     = 32'h0;
    dmem.DMemAck   = 1'b0;
    dmem.DMemRData = 32'h0;
    stepClk();
    chk("stall_in_reset", 32'(StallM), 32'h0);
    stepClk();
    rst      = 1'b0;
    MemReadM = 1'b0;
    #1;
    chkAllZero("reset");
    rdmModel = 32'h0;

    // Zero-wait load.
    doAccess(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);
    // Store with 3 wait cycles; RDM must keep DEADBEEF.
    doAccess(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 3);

    // Reset in the second REQ cycle, then a late ack.
    MemReadM = 1'b1;
    ALUOutM  = 32'h40;
    stepClk();
    stepClk();
    chk("rst_mid_req_active", 32'(dmem.DMemReq), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(StallM), 32'h0);
    stepClk();
    rst            = 1'b0;
    MemReadM       = 1'b0;
    dmem.DMemAck   = 1'b1;
    dmem.DMemRData = 32'hCAFE_F00D;
    #1;
    chkAllZero("rst_mid");
    stepClk();
    chkAllZero("late_ack");
    dmem.DMemAck = 1'b0;
    rdmModel = 32'h0;

    // Back-to-back zero-wait loads.
    doAccess(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'hA5A5_0004, 0);
    doAccess(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h5A5A_0008, 0);
    // Misaligned load.
    doAccess(1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'h7777_7777, 0);
    // Reload a non-zero value, then a load that never gets an ack.
    doAccess(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_1111, 1);
    doAccess(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h2222_2222, 99);
    // Read and write together: treated as a store.
    doAccess(1'b1, 1'b1, 32'h0000_0300, 32'hBEEF_0300, 32'h3333_3333, 0);

    // Randomized transactions with idle gaps and stray acks.
    for (int n = 0; n < 40; n++) begin
      idles = $urandom_range(0, 2);
      for (int k = 0; k < idles; k++) begin
        dmem.DMemAck   = 1'($urandom_range(0, 1));
        dmem.DMemRData = $urandom;
        #1;
        chk("rand_idle_stall", 32'(StallM), 32'h0);
        chk("rand_idle_req", 32'(dmem.DMemReq), 32'h0);
        stepClk();
        chk("rand_idle_rdm", RDM, rdmModel);
      end
      dmem.DMemAck = 1'b0;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      doAccess(rd, wr, a, $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
